// File: rtl/johnson_phase_monitor_if.sv
// Bundle between the Johnson counter consumer and its user: sampled code in,
// decoded phase, lock and fault status out.
interface johnson_phase_monitor_if #(
  parameter int unsigned REV_W = 8
);
  logic [3:0]       count;
  logic             sample_en;
  logic [2:0]       phase_idx;
  logic [7:0]       phase_onehot;
  logic             valid;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             error;
  logic             fault_seen;

  modport master (
    output count, sample_en,
    input  phase_idx, phase_onehot, valid, locked, rev_tick, rev_count, error, fault_seen
  );

  modport slave (
    input  count, sample_en,
    output phase_idx, phase_onehot, valid, locked, rev_tick, rev_count, error, fault_seen
  );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes a 4-bit Johnson code to a phase, tracks lock onto the legal forward
// sequence, counts revolutions while locked and flags sequence faults.
module johnson_phase_monitor #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned REV_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  johnson_phase_monitor_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_t;

  state_t           state_q;
  logic [3:0]       good_cnt_q;
  logic [2:0]       prev_idx_q;
  logic             prev_ok_q;
  logic [2:0]       phase_idx_q;
  logic [7:0]       onehot_q;
  logic             valid_q;
  logic             locked_q;
  logic             rev_tick_q;
  logic [REV_W-1:0] rev_cnt_q;
  logic             error_q;
  logic             fault_q;

  logic       code_ok;
  logic [2:0] code_idx;
  logic [2:0] prev_inc;
  logic       is_step;
  logic       is_hold;
  logic [4:0] good_cnt_d;
  logic       lock_hit;

  always_comb begin
    code_ok  = 1'b1;
    code_idx = 3'd0;
    case (bus.count)
      4'b0000: code_idx = 3'd0;
      4'b0001: code_idx = 3'd1;
      4'b0011: code_idx = 3'd2;
      4'b0111: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b1110: code_idx = 3'd5;
      4'b1100: code_idx = 3'd6;
      4'b1000: code_idx = 3'd7;
      default: code_ok  = 1'b0;
    endcase
  end

  // Anything legal that is neither a step nor a hold is a jump (incl. backwards).
  assign prev_inc   = prev_idx_q + 3'd1;
  assign is_step    = code_ok && prev_ok_q && (code_idx == prev_inc);
  assign is_hold    = code_ok && prev_ok_q && (code_idx == prev_idx_q);
  assign good_cnt_d = {1'b0, good_cnt_q} + 5'd1;
  assign lock_hit   = good_cnt_d >= 5'(LOCK_N);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      good_cnt_q  <= '0;
      prev_idx_q  <= '0;
      prev_ok_q   <= 1'b0;
      phase_idx_q <= '0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      rev_tick_q  <= 1'b0;
      rev_cnt_q   <= '0;
      error_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      rev_tick_q <= 1'b0;
      error_q    <= 1'b0;
      if (bus.sample_en) begin
        valid_q   <= code_ok;
        prev_ok_q <= code_ok;
        if (code_ok) begin
          phase_idx_q <= code_idx;
          prev_idx_q  <= code_idx;
          onehot_q    <= 8'(1) << code_idx;
        end else begin
          onehot_q    <= '0;
        end
        case (state_q)
          SEARCH: begin
            if (is_step) begin
              if (lock_hit) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_d[3:0];
              end
            end else if (!is_hold) begin
              good_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (is_step) begin
              if (code_idx == 3'd0) begin
                rev_cnt_q  <= rev_cnt_q + REV_W'(1);
                rev_tick_q <= 1'b1;
              end
            end else if (!is_hold) begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
              error_q  <= 1'b1;
              fault_q  <= 1'b1;
            end
          end
          FAULT: begin
            if (code_ok) begin
              state_q    <= SEARCH;
              good_cnt_q <= '0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus.phase_idx    = phase_idx_q;
  assign bus.phase_onehot = onehot_q;
  assign bus.valid        = valid_q;
  assign bus.locked       = locked_q;
  assign bus.rev_tick     = rev_tick_q;
  assign bus.rev_count    = rev_cnt_q;
  assign bus.error        = error_q;
  assign bus.fault_seen   = fault_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Table-driven check of johnson_phase_monitor: lock, revolutions, faults, holds,
// gated sampling and asynchronous reset, with a narrow-counter twin for wrap.
module tb_johnson_phase_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  johnson_phase_monitor_if #(.REV_W(8)) bus ();
  johnson_phase_monitor_if #(.REV_W(2)) bus2 ();
  assign bus2.count     = bus.count;
  assign bus2.sample_en = bus.sample_en;

  johnson_phase_monitor #(.LOCK_N(4), .REV_W(8)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  johnson_phase_monitor #(.LOCK_N(4), .REV_W(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));

  typedef struct {
    logic       rst_before;
    logic       en;
    logic [3:0] code;
    logic [2:0] idx;
    logic       valid;
    logic       locked;
    logic       tick;
    logic [7:0] rev;
    logic       err;
    logic       fault;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] C[8];
  logic       pend_rst;
  int         n_cmp;
  int         n_bad;

  task automatic add(input logic en, input logic [3:0] code, input int idx, input logic valid,
                     input logic locked, input logic tick, input int rev, input logic err,
                     input logic fault);
    vec_t v;
    v.rst_before = pend_rst;
    pend_rst     = 1'b0;
    v.en = en; v.code = code; v.idx = 3'(idx); v.valid = valid; v.locked = locked;
    v.tick = tick; v.rev = 8'(rev); v.err = err; v.fault = fault;
    tbl.push_back(v);
  endtask

  // Enabled sample followed by a disabled cycle carrying an illegal code: state must hold.
  task automatic addt(input logic [3:0] code, input int idx, input logic locked,
                      input logic tick, input int rev);
    add(1'b1, code, idx, 1'b1, locked, tick, rev, 1'b0, 1'b0);
    add(1'b0, 4'b0101, idx, 1'b1, locked, 1'b0, rev, 1'b0, 1'b0);
  endtask

  // One more revolution starting locked at idx 0; ends with the tick to 'rev'.
  task automatic add_rev(input int rev, input logic fault);
    for (int i = 1; i < 8; i++) add(1'b1, C[i], i, 1'b1, 1'b1, 1'b0, rev - 1, 1'b0, fault);
    add(1'b1, C[0], 0, 1'b1, 1'b1, 1'b1, rev, 1'b0, fault);
  endtask

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @vec %0d: got %0h, expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic check_zero(input int n);
    chk("rst.idx",    n, 32'(bus.phase_idx),    32'd0);
    chk("rst.onehot", n, 32'(bus.phase_onehot), 32'd0);
    chk("rst.valid",  n, 32'(bus.valid),        32'd0);
    chk("rst.locked", n, 32'(bus.locked),       32'd0);
    chk("rst.tick",   n, 32'(bus.rev_tick),     32'd0);
    chk("rst.rev",    n, 32'(bus.rev_count),    32'd0);
    chk("rst.err",    n, 32'(bus.error),        32'd0);
    chk("rst.fault",  n, 32'(bus.fault_seen),   32'd0);
    chk("rst.rev2",   n, 32'(bus2.rev_count),   32'd0);
    chk("rst.locked2",n, 32'(bus2.locked),      32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; pend_rst = 1'b0;
    C[0] = 4'b0000; C[1] = 4'b0001; C[2] = 4'b0011; C[3] = 4'b0111;
    C[4] = 4'b1111; C[5] = 4'b1110; C[6] = 4'b1100; C[7] = 4'b1000;

    // Lock after the 4th step past the initial jump, then two revolutions.
    for (int i = 1; i < 5; i++) add(1'b1, C[i], i, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) add(1'b1, C[i], i, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    add(1'b1, C[0], 0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    add_rev(2, 1'b0);
    // Illegal code while locked, then recover and relock.
    add(1'b1, C[1], 1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    add(1'b1, 4'b0101, 1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    for (int i = 2; i < 6; i++) add(1'b1, C[i], i, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    add(1'b1, C[6], 6, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    add(1'b1, C[7], 7, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    add(1'b1, C[0], 0, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b1);
    // Backward step while locked, then a step plus five holds in SEARCH.
    for (int i = 1; i < 4; i++) add(1'b1, C[i], i, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    add(1'b1, C[2], 2, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    add(1'b1, C[1], 1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) add(1'b1, C[2], 2, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    add(1'b1, C[3], 3, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    add(1'b1, C[4], 4, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    for (int i = 5; i < 8; i++) add(1'b1, C[i], i, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    add(1'b1, C[0], 0, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1);
    add_rev(5, 1'b1);
    for (int i = 1; i < 4; i++) add(1'b1, C[i], i, 1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    // Reset mid-revolution; next code would be a step but must count as a jump.
    pend_rst = 1'b1;
    addt(C[4], 4, 1'b0, 1'b0, 0);
    for (int i = 5; i < 8; i++) addt(C[i], i, 1'b0, 1'b0, 0);
    addt(C[0], 0, 1'b1, 1'b0, 0);
    for (int i = 1; i < 8; i++) addt(C[i], i, 1'b1, 1'b0, 0);
    addt(C[0], 0, 1'b1, 1'b1, 1);

    bus.sample_en = 1'b0;
    bus.count     = 4'b0000;
    #3 check_zero(-1);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      vec_t v;
      v = tbl[n];
      if (v.rst_before) begin
        #2 rst = 1'b1;
        #1 check_zero(n);
        @(negedge clk);
        rst = 1'b0;
      end
      bus.sample_en = v.en;
      bus.count     = v.code;
      @(posedge clk);
      #1;
      chk("idx",    n, 32'(bus.phase_idx),    32'(v.idx));
      chk("onehot", n, 32'(bus.phase_onehot), v.valid ? 32'(8'h01 << v.idx) : 32'd0);
      chk("valid",  n, 32'(bus.valid),        32'(v.valid));
      chk("locked", n, 32'(bus.locked),       32'(v.locked));
      chk("tick",   n, 32'(bus.rev_tick),     32'(v.tick));
      chk("rev",    n, 32'(bus.rev_count),    32'(v.rev));
      chk("error",  n, 32'(bus.error),        32'(v.err));
      chk("fault",  n, 32'(bus.fault_seen),   32'(v.fault));
      chk("rev2",   n, 32'(bus2.rev_count),   32'(v.rev[1:0]));
      chk("tick2",  n, 32'(bus2.rev_tick),    32'(v.tick));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
